udp_probe_packer: RTL and testbench
===================================

Name: udp_probe_packer

Overview:
Passive tap on the UDP receive byte stream. Packs bytes into 128-bit words with frame markers and an error flag. Drives the on-chip debug-probe capture core directly downstream:
- probe_word -> 128-bit data probe
- probe_valid, probe_sop, probe_eop, probe_err -> 1-bit probes

Applies no backpressure to the stream. Capture is gated per frame by an arm input.

Parameters:
MAX_FRAME_BYTES, 1518, bytes captured per frame before overflow truncation; range 1..65535.
CNT_W, 16, width of the byte counter and the frame counter.

Ports:
clk  input  1  single clock for all logic
rst  input  1  synchronous, active-high reset
arm  input  1  capture enable; sampled only at frame start
s_data  input  8  tapped stream byte
s_valid  input  1  byte qualifier
s_last  input  1  last byte of frame; valid only with s_valid
probe_word  output  128  packed bytes; byte k of word at bits [8k+7:8k], first byte at LSB
probe_valid  output  1  one-cycle strobe per emitted word
probe_sop  output  1  first word of frame; qualified by probe_valid
probe_eop  output  1  final word of frame; qualified by probe_valid
probe_err  output  1  frame overflowed; set on the eop word only

Behaviour:
- Reset: all outputs 0, pack buffer cleared, byte index 0, byte count 0, frame count 0, state IDLE. A reset mid-frame discards the partial frame. The remaining bytes of that frame go to DROP until s_last.
- States:
  - IDLE: on s_valid&arm -> CAPTURE; that byte is byte 0. On s_valid&!arm -> DROP. If s_last is also set in that cycle, the frame completes immediately and the state stays IDLE.
  - CAPTURE: pack bytes. When byte count reaches MAX_FRAME_BYTES without s_last -> OVERFLOW.
  - OVERFLOW: discard bytes; on s_valid&s_last -> IDLE.
  - DROP: discard bytes; on s_valid&s_last -> IDLE. Nothing is emitted.
- Packing:
  - 4-bit byte index wraps 15->0.
  - A word is emitted on the cycle after the byte that fills index 15, or after the s_last byte.
  - Latency is exactly 1 clk from the accepting edge to the probe_valid high cycle.
  - On s_last, unfilled upper bytes are zero.
  - The pack buffer is cleared after each emit.
- Markers:
  - probe_sop=1 on the first emitted word of a captured frame.
  - probe_eop=1 on the last. Both are 1 on the same word when the frame is 16 bytes or fewer.
  - Outputs are 0 when probe_valid=0.
- Overflow:
  - The byte at count MAX_FRAME_BYTES is the last packed. A full word completed at that byte is emitted normally, with sop if first.
  - Any partial word is held.
  - At s_last, one word is emitted: held bytes, zero-padded, or all-zero if none held, with eop=1 and err=1. sop=1 also if no prior word of the frame was emitted.
  - A frame of exactly MAX_FRAME_BYTES ending with s_last is not an overflow.
- Counters:
  - Byte count counts all frame bytes including discarded ones and saturates at 2^CNT_W-1.
  - Frame count increments at each captured frame's eop and wraps.
- s_valid=0 cycles are idle gaps anywhere; state is held.
- arm changes mid-frame have no effect until the next frame start.

Optional Feature:
PROBE_TRAILER_EN
- Defined:
  - Each captured frame ends with an extra trailer word, emitted the cycle after the last data word.
  - Trailer layout: [CNT_W-1:0] = byte count, [CNT_W+31:CNT_W] = frame count zero-extended to 32 bits, rest 0.
  - eop and err move to the trailer. The last data word has eop=0, err=0.
  - Collision with the next frame's first word: the trailer goes first, and the data word is delayed 1 clk through a one-entry skid register. No data is lost.
- Undefined: no trailer, no skid register; behaviour as above.

Test Plan:
- 16-byte frame 0x00..0x0F, arm=1 -> one word 0x0F0E..0100, sop=1, eop=1, err=0, probe_valid 1 clk after the last byte. With PROBE_TRAILER_EN: trailer low 16 bits = 0x0010, frame count = 0.
- 20-byte frame, bytes 0xA0+i, with idle gaps -> word1 sop=1 holding bytes 0xA0..0xAF. Word2 eop=1, bytes 0xB0..0xB3 in [31:0], [127:32]=0.
- MAX_FRAME_BYTES=24, 40-byte frame -> word1 sop=1 (bytes 0..15). Final word: bytes 16..23 in [63:0], zeros above, eop=1, err=1. Bytes 24..39 never appear.
- arm=0 at frame A start then set to 1 mid-frame A; frame B starts with arm=1 -> nothing emitted for A; B captured with sop. arm toggled to 0 mid-B -> B still captured fully.
- rst pulse after 7 bytes of a 30-byte frame -> no outputs for that frame. The next frame is captured normally. Frame count restarts at 0.
- PROBE_TRAILER_EN: 16-byte frame, then 1-byte frame (byte 0x5A) with s_last on the next cycle -> three consecutive probe_valid cycles: data word, trailer, then delayed word 0x..5A with sop=1 (eop on its own trailer next cycle).

Source files
------------

// File: rtl/udp_probe_packer.sv
// udp_probe_packer: passive UDP rx tap packing bytes into 128-bit probe words.
// Optional per-frame trailer word: define PROBE_TRAILER_EN.
module udp_probe_packer #(
  parameter int MAX_FRAME_BYTES = 1518,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         arm,
  input  logic [7:0]   s_data,
  input  logic         s_valid,
  input  logic         s_last,
  output logic [127:0] probe_word,
  output logic         probe_valid,
  output logic         probe_sop,
  output logic         probe_eop,
  output logic         probe_err
);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    OVERFLOW,
    DROP
  } state_t;

  state_t state;
  state_t state_nx;

  logic             in_frame;
  logic [127:0]     pack;
  logic [3:0]       idx;
  logic [CNT_W-1:0] byte_cnt;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] cnt_inc;
  logic             hit_max;
  logic             sent;
  logic             start;

  logic             take;
  logic             ovf_end;
  logic [127:0]     word_in;
  logic             new_vld;
  logic [127:0]     new_word;
  logic             new_sop;
  logic             new_eop;
  logic             new_err;

  logic             o_vld;
  logic [127:0]     o_word;
  logic             o_sop;
  logic             o_eop;
  logic             o_err;

`ifdef PROBE_TRAILER_EN
  logic             skid_vld;
  logic [127:0]     skid_word;
  logic             skid_sop;
  logic             skid_eop;
  logic             skid_err;
  logic             skid_ld;
  logic             skid_clr;
  logic             trl_pend;
  logic             trl_err;
  logic             fin;
  logic             fin_err;
  logic [CNT_W-1:0] frame_bytes;
  logic [127:0]     trl_word;
`endif

  // Follows the raw stream through reset so a frame cut by
  // reset is recognised and its tail dropped.
  always_ff @(posedge clk) begin
    if (s_valid) in_frame <= !s_last;
  end

  assign start    = (state == IDLE) && s_valid && arm && !in_frame;
  assign cnt_base = (state == IDLE) ? '0 : byte_cnt;
  assign cnt_inc  = (&cnt_base) ? cnt_base : cnt_base + 1'b1;
  assign hit_max  = (cnt_inc == CNT_W'(MAX_FRAME_BYTES));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (s_valid && !s_last) begin
          if (!start)       state_nx = DROP;
          else if (hit_max) state_nx = OVERFLOW;
          else              state_nx = CAPTURE;
        end
      end
      CAPTURE: begin
        if (s_valid) begin
          if (s_last)       state_nx = IDLE;
          else if (hit_max) state_nx = OVERFLOW;
        end
      end
      OVERFLOW, DROP: begin
        if (s_valid && s_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    take     = s_valid && (start || (state == CAPTURE));
    ovf_end  = s_valid && s_last && (state == OVERFLOW);
    word_in  = pack | (128'(s_data) << {idx, 3'b000});
    new_vld  = (take && ((idx == 4'hF) || s_last)) || ovf_end;
    new_word = take ? word_in : pack;
    new_sop  = start || !sent;
    new_eop  = s_last;
    new_err  = ovf_end;
  end

`ifdef PROBE_TRAILER_EN
  always_comb begin
    trl_word = '0;
    trl_word[CNT_W-1:0] = frame_bytes;
    trl_word[CNT_W+31:CNT_W] = 32'(frame_cnt);
  end
`endif

  // Output select; with trailers: trailer, then skid, then new word.
  always_comb begin
    o_vld  = 1'b0;
    o_word = '0;
    o_sop  = 1'b0;
    o_eop  = 1'b0;
    o_err  = 1'b0;
`ifdef PROBE_TRAILER_EN
    fin      = 1'b0;
    fin_err  = 1'b0;
    skid_ld  = 1'b0;
    skid_clr = 1'b0;
    if (trl_pend) begin
      o_vld   = 1'b1;
      o_word  = trl_word;
      o_eop   = 1'b1;
      o_err   = trl_err;
      skid_ld = new_vld && !skid_vld;
    end else if (skid_vld) begin
      o_vld    = 1'b1;
      o_word   = skid_word;
      o_sop    = skid_sop;
      fin      = skid_eop;
      fin_err  = skid_err;
      skid_clr = 1'b1;
      skid_ld  = new_vld;
    end else if (new_vld) begin
      o_vld   = 1'b1;
      o_word  = new_word;
      o_sop   = new_sop;
      fin     = new_eop;
      fin_err = new_err;
    end
`else
    if (new_vld) begin
      o_vld  = 1'b1;
      o_word = new_word;
      o_sop  = new_sop;
      o_eop  = new_eop;
      o_err  = new_err;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pack        <= '0;
      idx         <= '0;
      byte_cnt    <= '0;
      frame_cnt   <= '0;
      sent        <= 1'b0;
      probe_word  <= '0;
      probe_valid <= 1'b0;
      probe_sop   <= 1'b0;
      probe_eop   <= 1'b0;
      probe_err   <= 1'b0;
`ifdef PROBE_TRAILER_EN
      skid_vld    <= 1'b0;
      skid_word   <= '0;
      skid_sop    <= 1'b0;
      skid_eop    <= 1'b0;
      skid_err    <= 1'b0;
      trl_pend    <= 1'b0;
      trl_err     <= 1'b0;
      frame_bytes <= '0;
`endif
    end else begin
      if (s_valid) byte_cnt <= cnt_inc;
      if (new_vld) begin
        pack <= '0;
        idx  <= '0;
      end else if (take) begin
        pack <= word_in;
        idx  <= idx + 1'b1;
      end
      if (start)        sent <= new_vld;
      else if (new_vld) sent <= 1'b1;
      if (probe_valid && probe_eop)
        frame_cnt <= frame_cnt + 1'b1;
      probe_word  <= o_word;
      probe_valid <= o_vld;
      probe_sop   <= o_sop;
      probe_eop   <= o_eop;
      probe_err   <= o_err;
`ifdef PROBE_TRAILER_EN
      if (skid_ld) begin
        skid_vld  <= 1'b1;
        skid_word <= new_word;
        skid_sop  <= new_sop;
        skid_eop  <= new_eop;
        skid_err  <= new_err;
      end else if (skid_clr) begin
        skid_vld  <= 1'b0;
      end
      trl_pend <= fin;
      if (fin) trl_err <= fin_err;
      if (s_valid && s_last && (take || state == OVERFLOW))
        frame_bytes <= cnt_inc;
`endif
    end
  end

endmodule

// File: tb/tb_udp_probe_packer.sv
// Testbench for udp_probe_packer: randomized frames vs. a frame-level model.
// Honours PROBE_TRAILER_EN when defined for the build.
module tb_udp_probe_packer;

  localparam int MAXB = 24;

  logic         clk = 1'b0;
  logic         rst;
  logic         arm;
  logic [7:0]   s_data;
  logic         s_valid;
  logic         s_last;
  logic [127:0] probe_word;
  logic         probe_valid;
  logic         probe_sop;
  logic         probe_eop;
  logic         probe_err;

  udp_probe_packer #(
    .MAX_FRAME_BYTES(MAXB),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .arm(arm),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_last(s_last),
    .probe_word(probe_word),
    .probe_valid(probe_valid),
    .probe_sop(probe_sop),
    .probe_eop(probe_eop),
    .probe_err(probe_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] w;
    logic s;
    logic e;
    logic r;
    int c;
  } ent_t;

  ent_t got_q[$];
  ent_t exp_q[$];
  ent_t mon_e;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int fcnt = 0;
  int last_acc = 0;
  logic [7:0] fb [64];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (probe_valid === 1'b1) begin
      mon_e.w = probe_word;
      mon_e.s = probe_sop;
      mon_e.e = probe_eop;
      mon_e.r = probe_err;
      mon_e.c = cyc;
      got_q.push_back(mon_e);
    end else begin
      tests++;
      if ({probe_word, probe_sop, probe_eop, probe_err} !== 131'd0) begin
        fails++;
        $display("FAIL idle_zero got %h %b%b%b exp all zero",
                 probe_word, probe_sop, probe_eop, probe_err);
      end
    end
  end

  // Frame-level model: chunk captured bytes into 16-byte words.
  task automatic model_frame(input int len, input bit armv);
    int cap;
    int nw;
    bit ovf;
    bit rr;
    ent_t e;
    if (!armv) return;
    ovf = len > MAXB;
    cap = ovf ? MAXB : len;
    nw = ovf ? cap / 16 + 1 : (cap + 15) / 16;
    for (int w = 0; w < nw; w++) begin
      e.w = '0;
      for (int k = 0; k < 16; k++)
        if (w * 16 + k < cap) e.w[8*k +: 8] = fb[w*16+k];
      e.s = (w == 0);
      e.e = (w == nw - 1);
      e.r = ovf && e.e;
      e.c = 0;
`ifdef PROBE_TRAILER_EN
      if (e.e) begin
        rr = e.r;
        e.e = 1'b0;
        e.r = 1'b0;
        exp_q.push_back(e);
        e.w = '0;
        e.w[15:0] = 16'(len);
        e.w[47:16] = 32'(16'(fcnt));
        e.s = 1'b0;
        e.e = 1'b1;
        e.r = rr;
      end
`else
      rr = 1'b0;
`endif
      exp_q.push_back(e);
    end
    fcnt++;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    s_last = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bytes(input int from, input int to, input int len,
                            input bit armv, input bit flip, input bit gaps);
    for (int i = from; i < to; i++) begin
      if (gaps) idle($urandom_range(0, 2));
      s_valid = 1'b1;
      s_data = fb[i];
      s_last = (i == len - 1);
      arm = (i == from) ? armv : (flip ? !armv : 1'($urandom));
      if (s_last) last_acc = cyc + 1;
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_valid = 1'b1;
    s_last = 1'b1;
    s_data = 8'h00;
    arm = 1'b0;
    @(negedge clk);
    s_valid = 1'b0;
    s_last = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (probe_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_valid got %b exp 0", probe_valid);
    end
    tests++;
    if (probe_word !== 128'd0) begin
      fails++;
      $display("FAIL rst_word got %h exp 0", probe_word);
    end
    tests++;
    if ({probe_sop, probe_eop, probe_err} !== 3'b000) begin
      fails++;
      $display("FAIL rst_flags got %b exp 000",
               {probe_sop, probe_eop, probe_err});
    end
    got_q.delete();
    fcnt = 0;
  endtask

  task automatic test_single_word();
    for (int i = 0; i < 16; i++) fb[i] = 8'(i);
    model_frame(16, 1'b1);
    send_bytes(0, 16, 16, 1'b1, 1'b0, 1'b0);
    idle(8);
    tests++;
    if (got_q.size() !== exp_q.size()) begin
      fails++;
      $display("FAIL single_count got %0d exp %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests++;
      if ({got_q[i].w, got_q[i].s, got_q[i].e, got_q[i].r} !==
          {exp_q[i].w, exp_q[i].s, exp_q[i].e, exp_q[i].r}) begin
        fails++;
        $display("FAIL single[%0d] got %h %b%b%b exp %h %b%b%b", i,
                 got_q[i].w, got_q[i].s, got_q[i].e, got_q[i].r,
                 exp_q[i].w, exp_q[i].s, exp_q[i].e, exp_q[i].r);
      end
    end
    if (got_q.size() > 0) begin
      tests++;
      if (got_q[0].w !== 128'h0f0e0d0c0b0a09080706050403020100) begin
        fails++;
        $display("FAIL single_word got %h exp 0f0e..0100", got_q[0].w);
      end
      tests++;
      if (got_q[0].c !== last_acc) begin
        fails++;
        $display("FAIL single_latency got cyc %0d exp %0d", got_q[0].c, last_acc);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_gaps();
    for (int i = 0; i < 20; i++) fb[i] = 8'hA0 + 8'(i);
    model_frame(20, 1'b1);
    send_bytes(0, 20, 20, 1'b1, 1'b0, 1'b1);
    idle(8);
    tests++;
    if (got_q.size() !== exp_q.size()) begin
      fails++;
      $display("FAIL gaps_count got %0d exp %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests++;
      if ({got_q[i].w, got_q[i].s, got_q[i].e, got_q[i].r} !==
          {exp_q[i].w, exp_q[i].s, exp_q[i].e, exp_q[i].r}) begin
        fails++;
        $display("FAIL gaps[%0d] got %h %b%b%b exp %h %b%b%b", i,
                 got_q[i].w, got_q[i].s, got_q[i].e, got_q[i].r,
                 exp_q[i].w, exp_q[i].s, exp_q[i].e, exp_q[i].r);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 40; i++) fb[i] = 8'($urandom);
    model_frame(40, 1'b1);
    send_bytes(0, 40, 40, 1'b1, 1'b0, 1'b1);
    idle(8);
    tests++;
    if (got_q.size() !== exp_q.size()) begin
      fails++;
      $display("FAIL ovf_count got %0d exp %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests++;
      if ({got_q[i].w, got_q[i].s, got_q[i].e, got_q[i].r} !==
          {exp_q[i].w, exp_q[i].s, exp_q[i].e, exp_q[i].r}) begin
        fails++;
        $display("FAIL ovf[%0d] got %h %b%b%b exp %h %b%b%b", i,
                 got_q[i].w, got_q[i].s, got_q[i].e, got_q[i].r,
                 exp_q[i].w, exp_q[i].s, exp_q[i].e, exp_q[i].r);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_arm();
    for (int i = 0; i < 12; i++) fb[i] = 8'($urandom);
    model_frame(12, 1'b0);
    send_bytes(0, 12, 12, 1'b0, 1'b1, 1'b0);
    idle(2);
    for (int i = 0; i < 20; i++) fb[i] = 8'($urandom);
    model_frame(20, 1'b1);
    send_bytes(0, 20, 20, 1'b1, 1'b1, 1'b1);
    idle(8);
    tests++;
    if (got_q.size() !== exp_q.size()) begin
      fails++;
      $display("FAIL arm_count got %0d exp %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests++;
      if ({got_q[i].w, got_q[i].s, got_q[i].e, got_q[i].r} !==
          {exp_q[i].w, exp_q[i].s, exp_q[i].e, exp_q[i].r}) begin
        fails++;
        $display("FAIL arm[%0d] got %h %b%b%b exp %h %b%b%b", i,
                 got_q[i].w, got_q[i].s, got_q[i].e, got_q[i].r,
                 exp_q[i].w, exp_q[i].s, exp_q[i].e, exp_q[i].r);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_rst_mid();
    for (int i = 0; i < 30; i++) fb[i] = 8'($urandom);
    send_bytes(0, 7, 30, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    fcnt = 0;
    send_bytes(7, 30, 30, 1'b1, 1'b0, 1'b0);
    idle(3);
    for (int i = 0; i < 18; i++) fb[i] = 8'($urandom);
    model_frame(18, 1'b1);
    send_bytes(0, 18, 18, 1'b1, 1'b0, 1'b0);
    idle(8);
    tests++;
    if (got_q.size() !== exp_q.size()) begin
      fails++;
      $display("FAIL rstmid_count got %0d exp %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests++;
      if ({got_q[i].w, got_q[i].s, got_q[i].e, got_q[i].r} !==
          {exp_q[i].w, exp_q[i].s, exp_q[i].e, exp_q[i].r}) begin
        fails++;
        $display("FAIL rstmid[%0d] got %h %b%b%b exp %h %b%b%b", i,
                 got_q[i].w, got_q[i].s, got_q[i].e, got_q[i].r,
                 exp_q[i].w, exp_q[i].s, exp_q[i].e, exp_q[i].r);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int acc0;
    for (int i = 0; i < 16; i++) fb[i] = 8'(i);
    model_frame(16, 1'b1);
    send_bytes(0, 16, 16, 1'b1, 1'b0, 1'b0);
    acc0 = last_acc;
    fb[0] = 8'h5A;
    model_frame(1, 1'b1);
    send_bytes(0, 1, 1, 1'b1, 1'b0, 1'b0);
    idle(8);
    tests++;
    if (got_q.size() !== exp_q.size()) begin
      fails++;
      $display("FAIL b2b_count got %0d exp %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests++;
      if ({got_q[i].w, got_q[i].s, got_q[i].e, got_q[i].r} !==
          {exp_q[i].w, exp_q[i].s, exp_q[i].e, exp_q[i].r}) begin
        fails++;
        $display("FAIL b2b[%0d] got %h %b%b%b exp %h %b%b%b", i,
                 got_q[i].w, got_q[i].s, got_q[i].e, got_q[i].r,
                 exp_q[i].w, exp_q[i].s, exp_q[i].e, exp_q[i].r);
      end
      tests++;
      if (got_q[i].c !== acc0 + i) begin
        fails++;
        $display("FAIL b2b_cyc[%0d] got %0d exp %0d", i, got_q[i].c, acc0 + i);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random();
    int len;
    bit a;
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, 40);
      a = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < len; i++) fb[i] = 8'($urandom);
      model_frame(len, a);
      send_bytes(0, len, len, a, 1'b0, 1'($urandom));
      idle($urandom_range(1, 3));
    end
    idle(8);
    tests++;
    if (got_q.size() !== exp_q.size()) begin
      fails++;
      $display("FAIL rand_count got %0d exp %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests++;
      if ({got_q[i].w, got_q[i].s, got_q[i].e, got_q[i].r} !==
          {exp_q[i].w, exp_q[i].s, exp_q[i].e, exp_q[i].r}) begin
        fails++;
        $display("FAIL rand[%0d] got %h %b%b%b exp %h %b%b%b", i,
                 got_q[i].w, got_q[i].s, got_q[i].e, got_q[i].r,
                 exp_q[i].w, exp_q[i].s, exp_q[i].e, exp_q[i].r);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL timeout got no finish exp finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    arm = 1'b0;
    s_data = 8'h00;
    s_valid = 1'b0;
    s_last = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_word();
    test_gaps();
    test_overflow();
    test_arm();
    test_rst_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
